axis_pkt_rr_arbiter: RTL and testbench

Packet-granular round-robin arbiter merging NUM_PORTS AXI-Stream sources into one AXI-Stream sink. It sits between several packet sources (pcap replay streams in simulation, ingress ports in hardware) and the single-stream queueing datapath. It locks the grant from first beat to the `tlast` handshake so packets never interleave. It is synthesizable RTL, not a testbench utility.

---
 rtl/axis_arb_pkg.sv | 22 ++
 rtl/axis_rr_select.sv | 38 +++
 rtl/axis_pkt_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_axis_pkt_rr_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet round-robin AXI-Stream arbiter.
package axis_arb_pkg;

    localparam int MAX_PORTS  = 16;
    localparam int PORT_IDX_W = 4;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Index of the set bit in a one-hot vector; zero for an all-zero vector.
    function automatic logic [PORT_IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] onehot);
        logic [PORT_IDX_W-1:0] idx;
        idx = {PORT_IDX_W{1'b0}};
        for (int i = 0; i < MAX_PORTS; i++) begin
            idx = idx | (onehot[i] ? PORT_IDX_W'(i) : {PORT_IDX_W{1'b0}});
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_rr_select.sv
// Rotating priority encoder: first requester after last_grant wins, one-hot result.
module axis_rr_select
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 any_req
);

    // Distance of a port from the slot just after the previous winner.
    function automatic int rr_offset(input int port, input int last);
        int off;
        off = port - last - 1;
        return (off < 0) ? (off + NUM_PORTS) : off;
    endfunction

    int best_off_s;

    // Find the smallest rotated distance among requesters, then mark that port.
    always_comb begin
        best_off_s = NUM_PORTS;
        grant      = {NUM_PORTS{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            best_off_s = (req[p] && (rr_offset(p, int'(last_grant)) < best_off_s))
                       ? rr_offset(p, int'(last_grant)) : best_off_s;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            grant[p] = req[p] && (rr_offset(p, int'(last_grant)) == best_off_s);
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream sources into one sink.
// Optional per-port packet counters are built when AXIS_ARB_STATS_EN is defined.
module axis_pkt_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH      = AXIS_DATA_WIDTH / 8,
    parameter int USER_WIDTH      = 1
`ifdef AXIS_ARB_STATS_EN
    ,
    parameter int CNT_WIDTH       = 32
`endif
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic [NUM_PORTS-1:0]                 s_axis_tvalid_i,
    output logic [NUM_PORTS-1:0]                 s_axis_tready_o,
    input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0]      s_axis_tkeep_i,
    input  logic [NUM_PORTS-1:0]                 s_axis_tlast_i,
    input  logic [NUM_PORTS*USER_WIDTH-1:0]      s_axis_tuser_i,
    output logic                                 m_axis_tvalid_o,
    input  logic                                 m_axis_tready_i,
    output logic [AXIS_DATA_WIDTH-1:0]           m_axis_tdata_o,
    output logic [KEEP_WIDTH-1:0]                m_axis_tkeep_o,
    output logic                                 m_axis_tlast_o,
    output logic [USER_WIDTH-1:0]                m_axis_tuser_o,
    output logic [NUM_PORTS-1:0]                 grant_o,
    output logic                                 busy_o
`ifdef AXIS_ARB_STATS_EN
    ,
    input  logic                                 stats_clr_i,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]       pkt_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    arb_state_e             state_r;
    arb_state_e             state_nxt_s;
    logic [NUM_PORTS-1:0]   grant_r;
    logic [NUM_PORTS-1:0]   grant_nxt_s;
    logic [IDX_W-1:0]       last_grant_r;
    logic [IDX_W-1:0]       last_grant_nxt_s;
    logic [NUM_PORTS-1:0]   sel_grant_s;
    logic                   sel_any_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic                   pkt_done_s;

    axis_rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_select (
        .req        (s_axis_tvalid_i),
        .last_grant (last_grant_r),
        .grant      (sel_grant_s),
        .any_req    (sel_any_s)
    );

    assign grant_idx_s = IDX_W'(onehot_to_idx(MAX_PORTS'(grant_r)));

    // Grant is all-zero in IDLE, so the AND-OR mux also forces the idle outputs to zero.
    always_comb begin
        m_axis_tdata_o = {AXIS_DATA_WIDTH{1'b0}};
        m_axis_tkeep_o = {KEEP_WIDTH{1'b0}};
        m_axis_tuser_o = {USER_WIDTH{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            m_axis_tdata_o = m_axis_tdata_o
                | ({AXIS_DATA_WIDTH{grant_r[p]}} & s_axis_tdata_i[p*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH]);
            m_axis_tkeep_o = m_axis_tkeep_o
                | ({KEEP_WIDTH{grant_r[p]}} & s_axis_tkeep_i[p*KEEP_WIDTH +: KEEP_WIDTH]);
            m_axis_tuser_o = m_axis_tuser_o
                | ({USER_WIDTH{grant_r[p]}} & s_axis_tuser_i[p*USER_WIDTH +: USER_WIDTH]);
        end
    end

    assign m_axis_tvalid_o = |(grant_r & s_axis_tvalid_i);
    assign m_axis_tlast_o  = |(grant_r & s_axis_tlast_i);
    assign s_axis_tready_o = grant_r & {NUM_PORTS{m_axis_tready_i}};
    assign pkt_done_s      = m_axis_tvalid_o & m_axis_tready_i & m_axis_tlast_o;
    assign grant_o         = grant_r;
    assign busy_o          = (state_r == ARB_BUSY);

    // Next-state: arbitrate only in IDLE, release the lock on the tlast handshake.
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        last_grant_nxt_s = last_grant_r;
        case (state_r)
            ARB_IDLE: begin
                if (sel_any_s) begin
                    state_nxt_s = ARB_BUSY;
                    grant_nxt_s = sel_grant_s;
                end else begin
                    state_nxt_s = ARB_IDLE;
                    grant_nxt_s = {NUM_PORTS{1'b0}};
                end
            end
            ARB_BUSY: begin
                if (pkt_done_s) begin
                    state_nxt_s      = ARB_IDLE;
                    grant_nxt_s      = {NUM_PORTS{1'b0}};
                    last_grant_nxt_s = grant_idx_s;
                end else begin
                    state_nxt_s = ARB_BUSY;
                    grant_nxt_s = grant_r;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
                grant_nxt_s = {NUM_PORTS{1'b0}};
            end
        endcase
    end

    // Arbitration registers; reset makes port 0 the first winner.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r      <= ARB_IDLE;
            grant_r      <= {NUM_PORTS{1'b0}};
            last_grant_r <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            last_grant_r <= last_grant_nxt_s;
        end
    end

`ifdef AXIS_ARB_STATS_EN
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] pkt_cnt_r;

    // Completed-packet counters; a clear overrides a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pkt_cnt_r <= '0;
        end else if (stats_clr_i) begin
            pkt_cnt_r <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (pkt_done_s && grant_r[p]) begin
                    pkt_cnt_r[p] <= pkt_cnt_r[p] + CNT_WIDTH'(1);
                end else begin
                    pkt_cnt_r[p] <= pkt_cnt_r[p];
                end
            end
        end
    end

    assign pkt_cnt_o = pkt_cnt_r;
`endif

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed self-checking bench for axis_pkt_rr_arbiter (4 ports, 64-bit data).
module tb_axis_pkt_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [3:0]   s_valid = 4'h0;
    logic [3:0]   s_ready;
    logic [255:0] s_data = 256'h0;
    logic [31:0]  s_keep = 32'h0;
    logic [3:0]   s_last = 4'h0;
    logic [3:0]   s_user = 4'h0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [63:0]  m_data;
    logic [7:0]   m_keep;
    logic         m_last;
    logic         m_user;
    logic [3:0]   grant;
    logic         busy;
`ifdef AXIS_ARB_STATS_EN
    logic         stats_clr = 1'b0;
    logic [127:0] pkt_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] exp_g [15] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4,
                                4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
    logic [7:0] exp_d [15] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h11, 8'h00, 8'h20, 8'h21,
                                8'h00, 8'h30, 8'h31, 8'h00, 8'h00, 8'h01};
    logic [3:0] src_beat;
    logic [3:0] hs;

    axis_pkt_rr_arbiter dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .s_axis_tvalid_i (s_valid),
        .s_axis_tready_o (s_ready),
        .s_axis_tdata_i  (s_data),
        .s_axis_tkeep_i  (s_keep),
        .s_axis_tlast_i  (s_last),
        .s_axis_tuser_i  (s_user),
        .m_axis_tvalid_o (m_valid),
        .m_axis_tready_i (m_ready),
        .m_axis_tdata_o  (m_data),
        .m_axis_tkeep_o  (m_keep),
        .m_axis_tlast_o  (m_last),
        .m_axis_tuser_o  (m_user),
        .grant_o         (grant),
        .busy_o          (busy)
`ifdef AXIS_ARB_STATS_EN
        ,
        .stats_clr_i     (stats_clr),
        .pkt_cnt_o       (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic [63:0] d, input logic l);
        s_valid[p]        = v;
        s_data[p*64 +: 64] = d;
        s_keep[p*8 +: 8]   = 8'hFF;
        s_last[p]         = l;
        s_user[p]         = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // reset state
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_mvalid", 64'(m_valid), 64'h0);
        check("rst_sready", 64'(s_ready), 64'h0);
        check("rst_mdata", m_data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ports 0 and 2 request together: port 0 first (3 beats), then port 2
        m_ready = 1'b1;
        set_port(0, 1'b1, 64'hA000, 1'b0);
        set_port(2, 1'b1, 64'hA200, 1'b0);
        #1;
        check("t1_idle_grant", 64'(grant), 64'h0);
        check("t1_idle_sready", 64'(s_ready), 64'h0);
        check("t1_idle_mvalid", 64'(m_valid), 64'h0);
        @(negedge clk); #1;
        check("t1_grant_p0", 64'(grant), 64'h1);
        check("t1_b0_data", m_data, 64'hA000);
        check("t1_b0_sready", 64'(s_ready), 64'h1);
        check("t1_busy", 64'(busy), 64'h1);
        @(negedge clk);
        set_port(0, 1'b1, 64'hA001, 1'b0);
        #1;
        check("t1_b1_data", m_data, 64'hA001);
        @(negedge clk);
        set_port(0, 1'b1, 64'hA002, 1'b1);
        #1;
        check("t1_b2_data", m_data, 64'hA002);
        check("t1_b2_last", 64'(m_last), 64'h1);
        @(negedge clk);
        set_port(0, 1'b0, 64'h0, 1'b0);
        #1;
        check("t1_bubble_busy", 64'(busy), 64'h0);
        check("t1_bubble_grant", 64'(grant), 64'h0);
        @(negedge clk); #1;
        check("t1_grant_p2", 64'(grant), 64'h4);
        check("t1_p2_data", m_data, 64'hA200);
        @(negedge clk);
        set_port(2, 1'b1, 64'hA201, 1'b1);
        #1;
        check("t1_p2_last_data", m_data, 64'hA201);
        @(negedge clk);
        set_port(2, 1'b0, 64'h0, 1'b0);
        #1;
        check("t1_end_busy", 64'(busy), 64'h0);

        // all four ports stream 2-beat packets: order 0,1,2,3,0 with a bubble each
        do_reset();
        src_beat = 4'h0;
        for (int k = 0; k < 15; k++) begin
            for (int p = 0; p < 4; p++) begin
                set_port(p, 1'b1, 64'hD000 | 64'(p * 16) | 64'(src_beat[p]), src_beat[p]);
            end
            #1;
            hs = s_ready & s_valid;
            check($sformatf("t2_grant_c%0d", k), 64'(grant), 64'(exp_g[k]));
            check($sformatf("t2_data_c%0d", k), m_data,
                  (exp_g[k] != 4'h0) ? (64'hD000 | 64'(exp_d[k])) : 64'h0);
            src_beat = src_beat ^ hs;
            @(negedge clk);
        end
        s_valid = 4'h0;

        // port 1 three beats with sink stall; port 3 must wait for the tlast handshake
        set_port(1, 1'b1, 64'hB010, 1'b0);
        set_port(3, 1'b1, 64'hB030, 1'b1);
        #1;
        check("t3_idle_grant", 64'(grant), 64'h0);
        @(negedge clk); #1;
        check("t3_grant_p1", 64'(grant), 64'h2);
        check("t3_b0_sready", 64'(s_ready), 64'h2);
        @(negedge clk);
        set_port(1, 1'b1, 64'hB011, 1'b0);
        m_ready = 1'b0;
        #1;
        check("t3_stall_sready", 64'(s_ready), 64'h0);
        check("t3_stall_mvalid", 64'(m_valid), 64'h1);
        check("t3_stall_grant", 64'(grant), 64'h2);
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        check("t3_b1_data", m_data, 64'hB011);
        check("t3_b1_sready", 64'(s_ready), 64'h2);
        @(negedge clk);
        set_port(1, 1'b1, 64'hB012, 1'b1);
        #1;
        check("t3_b2_data", m_data, 64'hB012);
        check("t3_b2_grant", 64'(grant), 64'h2);
        @(negedge clk);
        set_port(1, 1'b0, 64'h0, 1'b0);
        #1;
        check("t3_bubble_grant", 64'(grant), 64'h0);
        check("t3_bubble_sready", 64'(s_ready), 64'h0);
        @(negedge clk); #1;
        check("t3_grant_p3", 64'(grant), 64'h8);
        check("t3_p3_data", m_data, 64'hB030);
        @(negedge clk);
        set_port(3, 1'b0, 64'h0, 1'b0);

        // single-beat packet on port 2 with sideband
        set_port(2, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1);
        s_keep[23:16] = 8'h0F;
        s_user[2]     = 1'b1;
        #1;
        check("t4_idle_busy", 64'(busy), 64'h0);
        @(negedge clk); #1;
        check("t4_busy", 64'(busy), 64'h1);
        check("t4_data", m_data, 64'h0123_4567_89AB_CDEF);
        check("t4_keep", 64'(m_keep), 64'h0F);
        check("t4_user", 64'(m_user), 64'h1);
        check("t4_last", 64'(m_last), 64'h1);
        @(negedge clk);
        set_port(2, 1'b0, 64'h0, 1'b0);
        #1;
        check("t4_busy_after", 64'(busy), 64'h0);

        // port 3 packet: valid gap mid-packet, then reset during the middle beat
        @(negedge clk);
        set_port(3, 1'b1, 64'hC030, 1'b0);
        @(negedge clk); #1;
        check("t5_grant_p3", 64'(grant), 64'h8);
        @(negedge clk);
        set_port(3, 1'b0, 64'hC031, 1'b0);
        #1;
        check("t5_gap_grant", 64'(grant), 64'h8);
        check("t5_gap_mvalid", 64'(m_valid), 64'h0);
        @(negedge clk);
        set_port(3, 1'b1, 64'hC031, 1'b0);
        @(negedge clk);
        set_port(3, 1'b1, 64'hC032, 1'b0);
        #1;
        check("t5_mid_data", m_data, 64'hC032);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_mvalid", 64'(m_valid), 64'h0);
        check("t5_rst_mdata", m_data, 64'h0);
        check("t5_rst_grant", 64'(grant), 64'h0);
        check("t5_rst_sready", 64'(s_ready), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_port(0, 1'b1, 64'hC000, 1'b1);
        @(negedge clk); #1;
        check("t5_after_grant_p0", 64'(grant), 64'h1);
        check("t5_after_data", m_data, 64'hC000);
        @(negedge clk);
        set_port(0, 1'b0, 64'h0, 1'b0);
        @(negedge clk); #1;
        check("t5_then_p3", 64'(grant), 64'h8);
        @(negedge clk);
        set_port(3, 1'b0, 64'h0, 1'b0);
        @(negedge clk);

`ifdef AXIS_ARB_STATS_EN
        // packet counters: 3 on port 1, 1 on port 0, then clear beside a tlast
        do_reset();
        set_port(1, 1'b1, 64'hE010, 1'b1);
        repeat (6) @(negedge clk);
        set_port(1, 1'b0, 64'h0, 1'b0);
        set_port(0, 1'b1, 64'hE000, 1'b1);
        repeat (2) @(negedge clk);
        set_port(0, 1'b0, 64'h0, 1'b0);
        @(negedge clk); #1;
        check("st_cnt_p1", 64'(pkt_cnt[63:32]), 64'd3);
        check("st_cnt_p0", 64'(pkt_cnt[31:0]), 64'd1);
        set_port(1, 1'b1, 64'hE011, 1'b1);
        @(negedge clk);
        stats_clr = 1'b1;
        #1;
        check("st_clr_grant", 64'(grant), 64'h2);
        @(negedge clk);
        stats_clr = 1'b0;
        set_port(1, 1'b0, 64'h0, 1'b0);
        #1;
        check("st_clr_p1", 64'(pkt_cnt[63:32]), 64'd0);
        check("st_clr_p0", 64'(pkt_cnt[31:0]), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
